// File: rtl/seg7_sequence_checker.sv
// Receive-side monitor for a 7-segment counter bus: debounces the segment pattern,
// decodes it to a digit, tracks count direction and flags illegal or skipped steps.
module seg7_sequence_checker #(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int STABLE_CYCLES  = 2,
  parameter int STALL_CYCLES   = 16,
  parameter int ERR_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             blank,
  output logic [1:0]       dir,
  output logic             rev_pulse,
  output logic             paused,
  output logic             seq_err,
  output logic             illegal_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int RL_W = $clog2(STABLE_CYCLES + 1);
  localparam int ST_W = $clog2(STALL_CYCLES + 1);
  localparam logic [RL_W-1:0] RL_MAX = RL_W'(STABLE_CYCLES);
  localparam logic [ST_W-1:0] ST_MAX = ST_W'(STALL_CYCLES);

  typedef enum logic [1:0] {IDLE, LOCKED, UP, DOWN} state_t;

  state_t          state;
  logic [6:0]      cur;
  logic [6:0]      last_accepted;
  logic [RL_W-1:0] rl;
  logic [ST_W-1:0] stall;

  logic [6:0]      s;
  logic [RL_W-1:0] rl_next;
  logic [ST_W-1:0] stall_inc;
  logic            accept;
  logic            is_legal;
  logic [3:0]      d;
  logic [3:0]      p_plus;
  logic [3:0]      p_minus;
  logic            step_up;
  logic            step_down;
  logic [ERR_W-1:0] err_inc;

  // Returns {legal, value}; blank and illegal both report legal=0.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  always_comb begin
    s = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
    if (s == cur) begin
      rl_next = (rl == RL_MAX) ? rl : rl + 1'b1;
    end else begin
      rl_next = RL_W'(1);
    end
    // The last_accepted guard is what stops a held or re-presented pattern re-accepting.
    accept    = (rl_next == RL_MAX) && (s != last_accepted);
    {is_legal, d} = decode(s);
    stall_inc = (stall == ST_MAX) ? stall : stall + 1'b1;
    p_plus    = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    p_minus   = (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    step_up   = (d == p_plus);
    step_down = (d == p_minus);
    err_inc   = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cur           <= 7'h00;
      rl            <= '0;
      last_accepted <= 7'h00;
      stall         <= '0;
      digit         <= 4'd0;
      digit_valid   <= 1'b0;
      blank         <= 1'b0;
      dir           <= 2'b00;
      rev_pulse     <= 1'b0;
      paused        <= 1'b0;
      seq_err       <= 1'b0;
      illegal_err   <= 1'b0;
      err_count     <= '0;
    end else begin
      cur         <= s;
      rl          <= rl_next;
      digit_valid <= 1'b0;
      rev_pulse   <= 1'b0;
      seq_err     <= 1'b0;
      illegal_err <= 1'b0;
      if (accept) begin
        last_accepted <= s;
        stall         <= '0;
        paused        <= 1'b0;
        if (is_legal) begin
          digit       <= d;
          digit_valid <= 1'b1;
          blank       <= 1'b0;
          case (state)
            IDLE: begin
              state <= LOCKED;
              dir   <= 2'b00;
            end
            default: begin
              if (step_up) begin
                state     <= UP;
                dir       <= 2'b01;
                rev_pulse <= (state == DOWN);
              end else if (step_down) begin
                state     <= DOWN;
                dir       <= 2'b10;
                rev_pulse <= (state == UP);
              end else begin
                state     <= LOCKED;
                dir       <= 2'b00;
                seq_err   <= 1'b1;
                err_count <= err_inc;
              end
            end
          endcase
        end else if (s == 7'h00) begin
          state <= IDLE;
          dir   <= 2'b00;
          blank <= 1'b1;
        end else begin
          // Illegal pattern drops the reference but keeps the last good digit visible.
          state       <= IDLE;
          dir         <= 2'b00;
          blank       <= 1'b0;
          illegal_err <= 1'b1;
          err_count   <= err_inc;
        end
      end else begin
        stall  <= stall_inc;
        paused <= (state != IDLE) && (stall_inc >= ST_MAX);
      end
    end
  end

endmodule

// File: doc/seg7_sequence_checker.md
Name: seg7_sequence_checker

Overview:
- Receive-side monitor for a 7-segment counter display bus.
- Filters glitches from the 7-bit segment pattern, then decodes it back to a decimal digit.
- Tracks count direction (up/down/paused) from successive digits, and flags illegal patterns and skipped steps.
- Sits on the counter's segment output, for self-check in simulation and for on-chip loopback test.

Parameters:
- SEG_ACTIVE_LOW, 0: 1 = segments active-low; seg_in is inverted at the input before all other logic.
- STABLE_CYCLES, 2: consecutive identical samples needed to accept a pattern; legal range >=1.
- STALL_CYCLES, 16: cycles with no accepted change before `paused` asserts; legal range >=2.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clock  in  1  Single system clock; all logic on its rising edge.
- reset  in  1  Synchronous, active-high reset.
- seg_in  in  7  Segment pattern, bit0=a ... bit6=g.
- digit  out  4  Last accepted legal digit, 0-9.
- digit_valid  out  1  One-cycle strobe when a new legal digit is accepted.
- blank  out  1  Level; 1 while the last accepted pattern is all-off.
- dir  out  2  Direction: 00 unknown, 01 up, 10 down.
- rev_pulse  out  1  One-cycle strobe when the direction flips between up and down.
- paused  out  1  Level; 1 after STALL_CYCLES with no accepted change.
- seq_err  out  1  One-cycle strobe on a non-adjacent step.
- illegal_err  out  1  One-cycle strobe on an accepted illegal pattern.
- err_count  out  ERR_W  Count of seq_err + illegal_err events; saturates at all-ones.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0; state IDLE.
  - Sample register cur = 0; run-length rl = 0; last_accepted = 7'h00; stall counter = 0.
- Decode table (active-high, gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - 00 is blank.
  - Every other value is illegal.
- Stability filter, every edge:
  - If s==cur: rl <= min(rl+1, STABLE_CYCLES).
  - Else: cur <= s, rl <= 1.
  - (s = seg_in after optional inversion.)
- Acceptance:
  - Occurs on the edge where rl reaches STABLE_CYCLES and s != last_accepted.
  - At most one acceptance per pattern run; re-presenting the same pattern does not re-accept.
  - Latency: a pattern first present before edge k is accepted at edge k+STABLE_CYCLES-1.
  - All outputs are registered; strobes are high for exactly the cycle following the accepting edge.
- FSM states:
  - IDLE: no reference digit.
  - LOCKED: reference digit, direction unknown.
  - UP, DOWN.
- Transitions on an accepted legal digit d, with previous digit p:
  - From IDLE: -> LOCKED; digit=d, digit_valid.
  - From LOCKED/UP/DOWN:
    - d == (p+1) mod 10 -> UP.
    - d == (p+9) mod 10 -> DOWN.
    - Otherwise -> seq_err, LOCKED.
  - digit and digit_valid are updated in every case.
  - UP->DOWN or DOWN->UP additionally pulses rev_pulse.
- Wrap-around is legal: 9->0 is up, 0->9 is down.
- Accepted blank: -> IDLE, blank=1, dir=00; no error and no digit_valid. blank clears on the next accepted legal digit.
- Accepted illegal pattern: -> IDLE, illegal_err, dir=00; digit holds its value.
- dir mapping: UP=01, DOWN=10, IDLE/LOCKED=00.
- Stall counter:
  - Clears on any acceptance; otherwise increments, saturating.
  - paused=1 while the counter >= STALL_CYCLES and state is UP, DOWN or LOCKED.
  - paused clears on the edge of the next acceptance.
  - While paused, the FSM state is retained, so a resumed adjacent step does not error.
- err_count increments by 1 per erroring acceptance; seq_err and illegal_err never coincide.
- reset asserted mid-operation overrides all other activity on that edge.

Test Plan:
- Reset mid-stream:
  - Stimulus: run an up sequence, then hold reset=1 for 2 cycles while seg_in=06.
  - Response: all outputs 0, dir=00, err_count=0.
  - Then, after release with 06 held, digit=1 and digit_valid pulses 2 edges later.
- Up count with wrap:
  - Stimulus: 7F, 6F, 3F, 06, each held 4 cycles, STABLE_CYCLES=2.
  - Response: digits 8, 9, 0, 1 each strobed once; dir=01 from the second digit on; no errors.
- Reversal:
  - Stimulus: 5B, 4F, 5B, 06.
  - Response: dir 00 -> 01 -> 10; rev_pulse once, on the third digit; dir stays 10 after 06; err_count=0.
- Glitch rejection:
  - Stimulus: 3F held 4 cycles, 4F held 1 cycle, 3F held 4 cycles.
  - Response: only one digit_valid (digit=0); no errors.
- Illegal and skipped patterns:
  - Stimulus: 06, 66 (1->4) -> seq_err, dir=00, err_count=1.
  - Stimulus: 49 held 3 cycles -> illegal_err, state IDLE, err_count=2.
  - Stimulus: 00 -> blank=1, no error.
- Pause:
  - Stimulus: 06, 5B, then hold 5B for 20 cycles.
  - Response: paused=1 from 16 cycles after acceptance, dir stays 01.
  - Stimulus: then 4F -> paused=0, digit_valid, no seq_err.
